lt_sequencer: RTL and testbench

//  Latency-test sequencer: drives lt_active/lt_mode of the 720x480 video generator,

---
 rtl/lt_sequencer_pkg.sv | 21 ++
 rtl/lt_sensor_sync.sv | 51 +++++
 rtl/lt_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_lt_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt_sequencer_pkg.sv
// Shared definitions for the latency-test sequencer: test-box position codes,
// FSM state encoding and result reset values.
package lt_sequencer_pkg;

  // Test box positions understood by the video generator
  localparam logic [1:0] LT_POS_TOPLEFT     = 2'd0;
  localparam logic [1:0] LT_POS_CENTER      = 2'd1;
  localparam logic [1:0] LT_POS_BOTTOMRIGHT = 2'd2;

  // Reset/clear value of the running minimum so the first sample always wins
  localparam logic [15:0] LAT_MIN_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC_WAIT = 3'd1,
    ST_FLASH     = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_COOLDOWN  = 3'd4
  } lt_state_e;

endpackage

// File: rtl/lt_sensor_sync.sv
// Photodiode input conditioning: two-flop synchroniser followed by a debounce
// counter. sensor_db only changes after DEBOUNCE consecutive cycles in which the
// synchronised input disagrees with it, so short light glitches are ignored.
module lt_sensor_sync #(
  parameter logic [7:0] DEBOUNCE = 8'd32
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic sensor_in,
  output logic sensor_db
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       db_q, db_d;
  logic [7:0] cnt_q, cnt_d;

  // Next-state for synchroniser and debounce counter
  always_comb begin
    sync1_d = sensor_in;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = 8'd0;
    if (sync2_q != db_q) begin
      if (cnt_q + 8'd1 >= DEBOUNCE) begin
        db_d  = sync2_q;
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // State registers, asynchronously cleared to "dark"
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sensor_db = db_q;

endmodule

// File: rtl/lt_sequencer.sv
// Latency-test sequencer: flashes the white test box at a frame boundary, times
// the photodiode response in microseconds and accumulates last/min/max over a run
// of NUM_SAMPLES flash/measure cycles.
module lt_sequencer
  import lt_sequencer_pkg::*;
#(
  parameter int unsigned US_DIV          = 27,
  parameter logic [15:0] TIMEOUT_US      = 16'd50000,
  parameter logic [7:0]  DEBOUNCE        = 8'd32,
  parameter logic [3:0]  COOLDOWN_FRAMES = 4'd3,
  parameter logic [3:0]  NUM_SAMPLES     = 4'd8
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  mode_in,
  input  logic        vsync_in,
  input  logic        sensor_in,
  output logic        lt_active,
  output logic [1:0]  lt_mode,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [3:0]  sample_cnt,
  output logic [15:0] lat_last,
  output logic [15:0] lat_min,
  output logic [15:0] lat_max
);

  localparam logic [7:0] PRESC_LAST = 8'(US_DIV - 1);

  lt_state_e   state_q, state_d;
  logic [7:0]  presc_q, presc_d;
  logic [15:0] us_q, us_d;
  logic [3:0]  frm_q, frm_d;
  logic        vsync_q;
  logic        lt_active_q, lt_active_d;
  logic [1:0]  lt_mode_q, lt_mode_d;
  logic        done_q, done_d;
  logic        terr_q, terr_d;
  logic [3:0]  samp_q, samp_d;
  logic [15:0] lat_last_q, lat_last_d;
  logic [15:0] lat_min_q, lat_min_d;
  logic [15:0] lat_max_q, lat_max_d;
  logic        sensor_db;
  logic        vs_fall;
  logic        timeout_hit;

  // Microsecond counter saturates rather than wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

  lt_sensor_sync #(
    .DEBOUNCE (DEBOUNCE)
  ) u_sensor_sync (
    .clk27     (clk27),
    .reset_n   (reset_n),
    .sensor_in (sensor_in),
    .sensor_db (sensor_db)
  );

  // VSYNC is active low: a high-to-low step marks the start of a frame
  assign vs_fall     = vsync_q & ~vsync_in;
  assign timeout_hit = (us_q == TIMEOUT_US);

  // Sequencer FSM: next state, test-pattern drive and result accumulation
  always_comb begin
    state_d     = state_q;
    lt_active_d = lt_active_q;
    lt_mode_d   = lt_mode_q;
    done_d      = 1'b0;
    terr_d      = terr_q;
    samp_d      = samp_q;
    lat_last_d  = lat_last_q;
    lat_min_d   = lat_min_q;
    lat_max_d   = lat_max_q;
    if (abort) begin
      // Results of the interrupted run are kept for inspection
      state_d     = ST_IDLE;
      lt_active_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_SYNC_WAIT;
            lt_mode_d  = mode_in;
            terr_d     = 1'b0;
            samp_d     = 4'd0;
            lat_last_d = 16'd0;
            lat_min_d  = LAT_MIN_INIT;
            lat_max_d  = 16'd0;
          end
        end
        ST_SYNC_WAIT: begin
          // A still-lit sensor would give a zero latency, so skip this frame
          if (vs_fall && !sensor_db) begin
            state_d     = ST_FLASH;
            lt_active_d = 1'b1;
          end
        end
        ST_FLASH: begin
          if (sensor_db) begin
            state_d     = ST_RELEASE;
            lt_active_d = 1'b0;
            lat_last_d  = us_q;
            lat_min_d   = min16(lat_min_q, us_q);
            lat_max_d   = max16(lat_max_q, us_q);
            samp_d      = samp_q + 4'd1;
          end else if (timeout_hit) begin
            state_d     = ST_IDLE;
            lt_active_d = 1'b0;
            terr_d      = 1'b1;
            done_d      = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!sensor_db) begin
            state_d = ST_COOLDOWN;
          end else if (timeout_hit) begin
            state_d     = ST_IDLE;
            lt_active_d = 1'b0;
            terr_d      = 1'b1;
            done_d      = 1'b1;
          end
        end
        ST_COOLDOWN: begin
          if (vs_fall && (frm_q + 4'd1 >= COOLDOWN_FRAMES)) begin
            if (samp_q >= NUM_SAMPLES) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_SYNC_WAIT;
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          lt_active_d = 1'b0;
        end
      endcase
    end
  end

  // Phase timer and cooldown frame counter, restarted on every state entry
  always_comb begin
    presc_d = presc_q;
    us_d    = us_q;
    frm_d   = frm_q;
    if (state_d != state_q) begin
      presc_d = 8'd0;
      us_d    = 16'd0;
      frm_d   = 4'd0;
    end else begin
      if (presc_q >= PRESC_LAST) begin
        presc_d = 8'd0;
        us_d    = sat_inc16(us_q);
      end else begin
        presc_d = presc_q + 8'd1;
      end
      if (state_q == ST_COOLDOWN && vs_fall) begin
        frm_d = frm_q + 4'd1;
      end
    end
  end

  // State and result registers; reset pulls lt_active low immediately
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      presc_q     <= 8'd0;
      us_q        <= 16'd0;
      frm_q       <= 4'd0;
      vsync_q     <= 1'b1;
      lt_active_q <= 1'b0;
      lt_mode_q   <= 2'd0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
      samp_q      <= 4'd0;
      lat_last_q  <= 16'd0;
      lat_min_q   <= LAT_MIN_INIT;
      lat_max_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      us_q        <= us_d;
      frm_q       <= frm_d;
      vsync_q     <= vsync_in;
      lt_active_q <= lt_active_d;
      lt_mode_q   <= lt_mode_d;
      done_q      <= done_d;
      terr_q      <= terr_d;
      samp_q      <= samp_d;
      lat_last_q  <= lat_last_d;
      lat_min_q   <= lat_min_d;
      lat_max_q   <= lat_max_d;
    end
  end

  assign lt_active   = lt_active_q;
  assign lt_mode     = lt_mode_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign sample_cnt  = samp_q;
  assign lat_last    = lat_last_q;
  assign lat_min     = lat_min_q;
  assign lat_max     = lat_max_q;

endmodule

// File: tb/tb_lt_sequencer.sv
// Bench for lt_sequencer with time-scaled parameters: a photodiode model answers
// each flash after a planned latency, expected run results are queued when a run
// is started and a monitor compares them whenever the DUT pulses done.
module tb_lt_sequencer;
  import lt_sequencer_pkg::*;

  localparam int          US_DIV = 27;
  localparam logic [15:0] TMO    = 16'd200;
  localparam logic [7:0]  DEB    = 8'd16;
  localparam logic [3:0]  COOL   = 4'd3;
  localparam logic [3:0]  NS     = 4'd8;
  localparam int          FRAME  = 300;
  localparam int          VS_LOW = 4;
  localparam int          HOLD   = 60;

  typedef struct {
    int lat;
    bit glitch;
  } samp_t;

  typedef struct {
    logic [15:0] last;
    logic [15:0] mn;
    logic [15:0] mx;
    logic [3:0]  cnt;
    logic        terr;
  } exp_t;

  logic        clk27 = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode_in = 2'd0;
  logic        vsync_in = 1'b1;
  logic        sens_raw = 1'b0;
  logic        stuck = 1'b0;
  logic        sensor_in;
  logic        lt_active;
  logic [1:0]  lt_mode;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [3:0]  sample_cnt;
  logic [15:0] lat_last;
  logic [15:0] lat_min;
  logic [15:0] lat_max;

  samp_t plan[$];
  exp_t  expq[$];
  int    total = 0;
  int    bad = 0;

  assign sensor_in = sens_raw | stuck;

  lt_sequencer #(
    .US_DIV          (US_DIV),
    .TIMEOUT_US      (TMO),
    .DEBOUNCE        (DEB),
    .COOLDOWN_FRAMES (COOL),
    .NUM_SAMPLES     (NS)
  ) dut (
    .clk27       (clk27),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .mode_in     (mode_in),
    .vsync_in    (vsync_in),
    .sensor_in   (sensor_in),
    .lt_active   (lt_active),
    .lt_mode     (lt_mode),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .sample_cnt  (sample_cnt),
    .lat_last    (lat_last),
    .lat_min     (lat_min),
    .lat_max     (lat_max)
  );

  initial forever #5 clk27 = ~clk27;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int req, input int tol);
    total++;
    if (act < req - tol || act > req + tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (+/-%0d)", nm, act, req, tol);
    end
  endtask

  // Free-running frame timing: VSYNC low for VS_LOW cycles every FRAME cycles
  initial begin
    forever begin
      repeat (FRAME - VS_LOW) @(negedge clk27);
      vsync_in = 1'b0;
      repeat (VS_LOW) @(negedge clk27);
      vsync_in = 1'b1;
    end
  end

  // Photodiode model: light appears a planned latency after each flash starts
  initial begin
    samp_t s;
    int    waited;
    forever begin
      @(posedge lt_active);
      if (plan.size() > 0) begin
        s = plan.pop_front();
        waited = 0;
        if (s.glitch) begin
          repeat (100) @(negedge clk27);
          sens_raw = 1'b1;
          repeat (10) @(negedge clk27);
          sens_raw = 1'b0;
          waited = 110;
        end
        repeat (s.lat * US_DIV - waited) @(negedge clk27);
        sens_raw = 1'b1;
        repeat (HOLD) @(negedge clk27);
        sens_raw = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every done pulse must match the oldest queued result
  always @(negedge clk27) begin
    exp_t e;
    if (reset_n && done) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        e = expq.pop_front();
        chk_tol("lat_last", int'(lat_last), int'(e.last), 1);
        chk_tol("lat_min", int'(lat_min), int'(e.mn), 1);
        chk_tol("lat_max", int'(lat_max), int'(e.mx), 1);
        chk("sample_cnt", int'(sample_cnt), int'(e.cnt));
        chk("timeout_err", int'(timeout_err), int'(e.terr));
        chk("lt_active_at_done", int'(lt_active), 0);
      end
    end
  end

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk27);
    mode_in = m;
    start = 1'b1;
    @(negedge clk27);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk27);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s: got no done within %0d cycles want done", nm, budget);
    end
    @(negedge clk27);
  endtask

  task automatic wait_active(input int budget, input string nm);
    int n = 0;
    while (!lt_active && n < budget) begin
      @(negedge clk27);
      n++;
    end
    if (!lt_active) begin
      total++;
      bad++;
      $display("FAIL %s: got lt_active=0 after %0d cycles want 1", nm, budget);
    end
  endtask

  initial begin
    int   hits;
    exp_t e;

    // Reset values
    reset_n = 1'b0;
    repeat (3) @(negedge clk27);
    chk("rst_lt_active", int'(lt_active), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_sample_cnt", int'(sample_cnt), 0);
    chk("rst_lat_last", int'(lat_last), 0);
    chk("rst_lat_min", int'(lat_min), 16'hFFFF);
    chk("rst_lat_max", int'(lat_max), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk27);

    // Eight identical samples of 40 us
    for (int i = 0; i < 8; i++) plan.push_back('{lat: 40, glitch: 1'b0});
    e = '{last: 16'd40, mn: 16'd40, mx: 16'd40, cnt: 4'd8, terr: 1'b0};
    expq.push_back(e);
    pulse_start(LT_POS_CENTER);
    chk("run1_lt_mode", int'(lt_mode), int'(LT_POS_CENTER));
    wait_done(40000, "run1_done");
    chk("run1_busy_after", int'(busy), 0);

    // Mixed latencies, first flash preceded by a short glitch
    plan.push_back('{lat: 30, glitch: 1'b1});
    plan.push_back('{lat: 25, glitch: 1'b0});
    plan.push_back('{lat: 45, glitch: 1'b0});
    plan.push_back('{lat: 40, glitch: 1'b0});
    plan.push_back('{lat: 30, glitch: 1'b0});
    plan.push_back('{lat: 35, glitch: 1'b0});
    plan.push_back('{lat: 40, glitch: 1'b0});
    plan.push_back('{lat: 35, glitch: 1'b0});
    e = '{last: 16'd35, mn: 16'd25, mx: 16'd45, cnt: 4'd8, terr: 1'b0};
    expq.push_back(e);
    pulse_start(LT_POS_BOTTOMRIGHT);
    wait_done(40000, "run2_done");

    // Sensor never responds: FLASH times out
    e = '{last: 16'd0, mn: 16'hFFFF, mx: 16'd0, cnt: 4'd0, terr: 1'b1};
    expq.push_back(e);
    pulse_start(LT_POS_TOPLEFT);
    wait_done(8000, "timeout_done");
    chk("timeout_busy_after", int'(busy), 0);

    // Abort during FLASH, with a start issued mid-run that must be ignored
    plan.push_back('{lat: 100, glitch: 1'b0});
    pulse_start(LT_POS_CENTER);
    chk("abort_terr_cleared", int'(timeout_err), 0);
    wait_active(1000, "abort_flash_entry");
    repeat (20) @(negedge clk27);
    pulse_start(LT_POS_BOTTOMRIGHT);
    chk("abort_mode_kept", int'(lt_mode), int'(LT_POS_CENTER));
    chk("abort_busy_before", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk27);
    abort = 1'b0;
    chk("abort_lt_active", int'(lt_active), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_lat_min_kept", int'(lat_min), 16'hFFFF);
    repeat (100 * US_DIV + 200) @(negedge clk27);

    // Sensor stuck high: flash must never start
    stuck = 1'b1;
    repeat (40) @(negedge clk27);
    pulse_start(LT_POS_TOPLEFT);
    hits = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk27);
      if (lt_active) hits++;
    end
    chk("stuck_lt_active_cycles", hits, 0);
    chk("stuck_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk27);
    abort = 1'b0;
    stuck = 1'b0;
    repeat (40) @(negedge clk27);

    // Asynchronous reset in the middle of a flash
    plan.push_back('{lat: 100, glitch: 1'b0});
    pulse_start(LT_POS_CENTER);
    wait_active(1000, "rstmid_flash_entry");
    repeat (10) @(negedge clk27);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_lt_active", int'(lt_active), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_lt_mode", int'(lt_mode), 0);

    chk("pending_results", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
